// File: rtl/sram_req_tracker_pkg.sv
// Shared definitions for the SRAM request tracker:
// flush sources and counter/pointer width helpers.
package sram_req_tracker_pkg;

   typedef enum logic [1:0] {
      FLUSH_NONE = 2'b00,
      FLUSH_EX   = 2'b01,
      FLUSH_ERET = 2'b10
   } flush_src_e;

   function automatic int cnt_w(input int max_out);
      return $clog2(max_out + 1);
   endfunction

   // A single-entry FIFO still needs a 1-bit pointer.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sram_req_tracker_if.sv
// SRAM-like request/response bus (req/addr_ok/data_ok).
// master = requester/tracker side, slave = SRAM side.
interface sram_req_tracker_if #(
   parameter int DATA_W = 32
);
   logic              sram_req;
   logic              sram_addr_ok;
   logic              sram_data_ok;
   logic [DATA_W-1:0] sram_rdata;

   modport master (
      output sram_req,
      input  sram_addr_ok,
      input  sram_data_ok,
      input  sram_rdata
   );

   modport slave (
      input  sram_req,
      output sram_addr_ok,
      output sram_data_ok,
      output sram_rdata
   );
endinterface

// File: rtl/sram_req_tracker_fifo.sv
// In-order tag FIFO for the request tracker.
// Pointers wrap at DEPTH-1; storage is not reset.
module sync_tag_fifo
   import sram_req_tracker_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32,
   parameter int CNT_W = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/sram_req_tracker.sv
// Outstanding-request tracker for one SRAM channel: tags each
// request, returns tags with responses, discards stale ones on flush.
module sram_req_tracker
   import sram_req_tracker_pkg::*;
#(
   parameter int MAX_OUT = 2,
   parameter int TAG_W   = 32,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = cnt_w(MAX_OUT)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                up_req,
   input  logic [TAG_W-1:0]    up_tag,
   output logic                up_ready,
   sram_req_tracker_if.master  bus,
   output logic                resp_valid,
   output logic [DATA_W-1:0]   resp_data,
   output logic [TAG_W-1:0]    resp_tag,
   output logic                busy,
   output logic [CNT_W-1:0]    count,
   output logic [CNT_W-1:0]    discard_cnt,
   output logic                err
);

   logic             accept;
   logic             pop;
   logic [CNT_W-1:0] disc_q, disc_d;
   logic             err_q, err_d;

   sync_tag_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (TAG_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (pop),
      .din   (up_tag),
      .head  (resp_tag),
      .count (count)
   );

   // Full check uses the registered count; a same-cycle pop does not free a slot.
   assign bus.sram_req = up_req & ~flush & (count < CNT_W'(MAX_OUT));
   assign accept       = bus.sram_req & bus.sram_addr_ok;
   assign pop          = bus.sram_data_ok & (count != '0);

   assign up_ready    = accept;
   assign resp_valid  = pop & (disc_q == '0) & ~flush;
   assign resp_data   = bus.sram_rdata;
   assign busy        = (count != '0);
   assign discard_cnt = disc_q;
   assign err         = err_q;

   // On flush every surviving in-flight entry becomes stale.
   always_comb begin
      disc_d = disc_q;
      if (flush) begin
         disc_d = count - CNT_W'(pop);
      end else if (pop && disc_q != '0) begin
         disc_d = disc_q - CNT_W'(1);
      end
      err_d = err_q | (bus.sram_data_ok & (count == '0));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         disc_q <= '0;
         err_q  <= 1'b0;
      end else begin
         disc_q <= disc_d;
         err_q  <= err_d;
      end
   end

endmodule
